// File: rtl/sp_req_arbiter.sv
// Scratchpad request arbiter: round-robin MLS/GEMM onto one FIFO write port, packs 38-bit words, fences new-weight GEMM ops.
// Latency: 0 cycles (grant, ready, sp_wen and sp_wdata combinational from valid); state updates on the next CLK edge.
// Backpressure: sp_full stalls every push; loads also stall at MAX_LD outstanding, and MLS stalls entirely while fenced.
// Ports: CLK/nRST; mls_* and gemm_* request channels (valid held until ready); gemm_flush aborts a fence;
//        sp_full/sp_wen/sp_wdata FIFO write side; sp_ld_done load completion pulse;
//        ld_outstanding, fence_busy and arb_err for status.
module sp_req_arbiter #(
  parameter int MAX_LD = 4,
  parameter int CNT_W  = $clog2(MAX_LD + 1)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             mls_valid,
  output logic             mls_ready,
  input  logic [1:0]       mls_ls,
  input  logic [3:0]       mls_rd,
  input  logic [31:0]      mls_addr,
  input  logic             gemm_valid,
  output logic             gemm_ready,
  input  logic             gemm_new_weight,
  input  logic [15:0]      gemm_sel,
  input  logic             gemm_flush,
  input  logic             sp_full,
  output logic             sp_wen,
  output logic [37:0]      sp_wdata,
  input  logic             sp_ld_done,
  output logic [CNT_W-1:0] ld_outstanding,
  output logic             fence_busy,
  output logic             arb_err
);

  typedef enum logic {ST_RUN, ST_FENCE} state_t;

  state_t           state, state_nxt;
  logic             rr_last;      // 1: GEMM pushed last, 0: MLS pushed last
  logic [CNT_W-1:0] ld_cnt;

  logic mls_ld, mls_st, mls_ill;
  logic mls_elig, gemm_elig;
  logic mls_grant, gemm_grant;
  logic ld_inc, ld_dec;

  // Request decode and eligibility
  always_comb begin
    mls_ld  = mls_valid && (mls_ls == 2'b01);
    mls_st  = mls_valid && (mls_ls == 2'b10);
    // Illegal encodings are swallowed regardless of fence or FIFO state so
    // a misbehaving MLS cannot wedge the port.
    mls_ill = mls_valid && ((mls_ls == 2'b00) || (mls_ls == 2'b11));

    mls_elig  = !sp_full && (state == ST_RUN) &&
                ((mls_ld && (ld_cnt < CNT_W'(MAX_LD))) || mls_st);
    // A flush cycle never grants GEMM: the flushed op is being abandoned.
    gemm_elig = !sp_full && gemm_valid && !gemm_flush &&
                (!gemm_new_weight || (ld_cnt == '0));

    // On a tie the side that did not push last wins.
    mls_grant  = mls_elig && (!gemm_elig || rr_last);
    gemm_grant = gemm_elig && !mls_grant;

    ld_inc = mls_grant && mls_ld;
    // Completion with nothing outstanding is a protocol error, not a decrement.
    ld_dec = sp_ld_done && (ld_cnt != '0);
  end

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        // ld_cnt != 0 already implies the new-weight GEMM was not granted.
        if (gemm_valid && gemm_new_weight && (ld_cnt != '0) && !gemm_flush)
          state_nxt = ST_FENCE;
      end
      ST_FENCE: begin
        if (gemm_flush || !gemm_valid || gemm_grant)
          state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Outputs
  always_comb begin
    mls_ready      = mls_grant || mls_ill;
    gemm_ready     = gemm_grant;
    sp_wen         = mls_grant || gemm_grant;
    sp_wdata       = '0;
    if (mls_grant)
      sp_wdata = {mls_ls, mls_rd, mls_addr};
    else if (gemm_grant)
      sp_wdata = {2'b11, gemm_new_weight, 3'b000, 16'h0000, gemm_sel};
    arb_err        = mls_ill || (sp_ld_done && (ld_cnt == '0));
    fence_busy     = (state == ST_FENCE);
    ld_outstanding = ld_cnt;
  end

  // Round-robin pointer and outstanding-load counter
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rr_last <= 1'b1;
      ld_cnt  <= '0;
    end else begin
      if (gemm_flush)
        rr_last <= 1'b1;
      else if (mls_grant)
        rr_last <= 1'b0;
      else if (gemm_grant)
        rr_last <= 1'b1;

      case ({ld_inc, ld_dec})
        2'b10:   ld_cnt <= ld_cnt + CNT_W'(1);
        2'b01:   ld_cnt <= ld_cnt - CNT_W'(1);
        default: ld_cnt <= ld_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_sp_req_arbiter.sv
module tb_sp_req_arbiter;
  localparam int MAX_LD = 4;
  localparam int CNT_W  = $clog2(MAX_LD + 1);

  logic             CLK = 1'b0;
  logic             nRST;
  logic             mls_valid, mls_ready;
  logic [1:0]       mls_ls;
  logic [3:0]       mls_rd;
  logic [31:0]      mls_addr;
  logic             gemm_valid, gemm_ready, gemm_new_weight, gemm_flush;
  logic [15:0]      gemm_sel;
  logic             sp_full, sp_wen, sp_ld_done;
  logic [37:0]      sp_wdata;
  logic [CNT_W-1:0] ld_outstanding;
  logic             fence_busy, arb_err;

  sp_req_arbiter #(.MAX_LD(MAX_LD)) dut (
    .CLK(CLK), .nRST(nRST),
    .mls_valid(mls_valid), .mls_ready(mls_ready), .mls_ls(mls_ls),
    .mls_rd(mls_rd), .mls_addr(mls_addr),
    .gemm_valid(gemm_valid), .gemm_ready(gemm_ready),
    .gemm_new_weight(gemm_new_weight), .gemm_sel(gemm_sel), .gemm_flush(gemm_flush),
    .sp_full(sp_full), .sp_wen(sp_wen), .sp_wdata(sp_wdata), .sp_ld_done(sp_ld_done),
    .ld_outstanding(ld_outstanding), .fence_busy(fence_busy), .arb_err(arb_err)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  logic [37:0] exp_q[$];

  typedef struct {
    logic mv; logic [1:0] ls; logic [3:0] rd; logic [31:0] addr;
    logic gv; logic nw; logic [15:0] sel; logic fl; logic full; logic done;
    logic mr; logic gr; logic wen; logic err; int cnt; logic fb; logic [37:0] word;
  } vec_t;
  vec_t vq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every push seen on the FIFO port must match the oldest expected word.
  always @(negedge CLK) begin
    if (nRST === 1'b1 && sp_wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_push actual=0x%0h expected=no push", sp_wdata);
      end else begin
        automatic logic [37:0] e = exp_q.pop_front();
        chk("sp_wdata", {26'h0, sp_wdata}, {26'h0, e});
      end
    end
  end

  task automatic add(input logic mv, input logic [1:0] ls, input logic [3:0] rd, input logic [31:0] addr,
                     input logic gv, input logic nw, input logic [15:0] sel, input logic fl,
                     input logic full, input logic done,
                     input logic mr, input logic gr, input logic wen, input logic err,
                     input int cnt, input logic fb, input logic [37:0] word);
    vec_t v;
    v.mv = mv; v.ls = ls; v.rd = rd; v.addr = addr; v.gv = gv; v.nw = nw; v.sel = sel;
    v.fl = fl; v.full = full; v.done = done; v.mr = mr; v.gr = gr; v.wen = wen;
    v.err = err; v.cnt = cnt; v.fb = fb; v.word = word;
    vq.push_back(v);
  endtask

  task automatic set_idle();
    mls_valid = 0; mls_ls = 2'b00; mls_rd = 4'h0; mls_addr = 32'h0;
    gemm_valid = 0; gemm_new_weight = 0; gemm_sel = 16'h0; gemm_flush = 0;
    sp_full = 0; sp_ld_done = 0;
  endtask

  task automatic settle();
    @(negedge CLK);
  endtask

  task automatic next();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic mr, input logic gr, input logic wen,
                         input logic err, input int cnt, input logic fb);
    chk({tag, ".mls_ready"}, mls_ready, mr);
    chk({tag, ".gemm_ready"}, gemm_ready, gr);
    chk({tag, ".sp_wen"}, sp_wen, wen);
    chk({tag, ".arb_err"}, arb_err, err);
    chk({tag, ".ld_outstanding"}, ld_outstanding, cnt);
    chk({tag, ".fence_busy"}, fence_busy, fb);
  endtask

  task automatic mls_req(input logic [1:0] ls, input logic [3:0] rd, input logic [31:0] addr);
    mls_valid = 1; mls_ls = ls; mls_rd = rd; mls_addr = addr;
  endtask

  initial begin
    // mv ls rd addr | gv nw sel fl full done || mr gr wen err cnt fb word
    add(0,2'b00,4'h0,32'h0,        0,0,16'h0,   0,0,0, 0,0,0,0,0,0,38'h0);
    add(1,2'b10,4'h5,32'h2000_0000, 1,0,16'h00A5,0,0,0, 1,0,1,0,0,0,38'h2_5_2000_0000);
    add(1,2'b10,4'h5,32'h2000_0000, 1,0,16'h00A5,0,0,0, 0,1,1,0,0,0,38'h3_0_0000_00A5);
    add(1,2'b10,4'h5,32'h2000_0000, 1,0,16'h00A5,0,0,0, 1,0,1,0,0,0,38'h2_5_2000_0000);
    add(1,2'b10,4'h5,32'h2000_0000, 1,0,16'h00A5,0,0,0, 0,1,1,0,0,0,38'h3_0_0000_00A5);
    add(1,2'b01,4'h3,32'h1000_0040, 0,0,16'h0,   0,0,0, 1,0,1,0,0,0,38'h1_3_1000_0040);
    add(0,2'b00,4'h0,32'h0,        0,0,16'h0,   0,0,0, 0,0,0,0,1,0,38'h0);
    add(0,2'b00,4'h0,32'h0,        0,0,16'h0,   0,0,1, 0,0,0,0,1,0,38'h0);
    add(1,2'b11,4'h2,32'h0,        0,0,16'h0,   0,1,0, 1,0,0,1,0,0,38'h0);
    add(0,2'b00,4'h0,32'h0,        0,0,16'h0,   0,0,1, 0,0,0,1,0,0,38'h0);
    add(0,2'b00,4'h0,32'h0,        0,0,16'h0,   0,0,0, 0,0,0,0,0,0,38'h0);
    add(0,2'b00,4'h0,32'h0,        1,0,16'h0001,0,1,0, 0,0,0,0,0,0,38'h0);
    add(1,2'b10,4'h1,32'h0,        0,0,16'h0,   0,1,0, 0,0,0,0,0,0,38'h0);
    add(1,2'b00,4'h1,32'h0,        1,0,16'h1234,0,0,0, 1,1,1,1,0,0,38'h3_0_0000_1234);
    add(0,2'b00,4'h0,32'h0,        1,1,16'hBEEF,0,0,0, 0,1,1,0,0,0,38'h3_8_0000_BEEF);
    add(0,2'b00,4'h0,32'h0,        0,0,16'h0,   0,0,0, 0,0,0,0,0,0,38'h0);

    set_idle();
    nRST = 0;
    settle();
    chk_out("reset", 0, 0, 0, 0, 0, 0);
    nRST = 1;
    next();

    for (int i = 0; i < vq.size(); i++) begin
      vec_t v;
      v = vq[i];
      mls_valid = v.mv; mls_ls = v.ls; mls_rd = v.rd; mls_addr = v.addr;
      gemm_valid = v.gv; gemm_new_weight = v.nw; gemm_sel = v.sel; gemm_flush = v.fl;
      sp_full = v.full; sp_ld_done = v.done;
      if (v.wen) exp_q.push_back(v.word);
      settle();
      chk_out($sformatf("vec%0d", i), v.mr, v.gr, v.wen, v.err, v.cnt, v.fb);
      if (!v.wen) chk($sformatf("vec%0d.wdata_idle", i), {26'h0, sp_wdata}, 64'h0);
      next();
    end
    set_idle();

    // Fill to MAX_LD, then the next load stalls until a completion frees a slot.
    for (int i = 0; i < MAX_LD; i++) begin
      mls_req(2'b01, 4'(i), 32'h3000_0000 + 32'(i * 64));
      exp_q.push_back({2'b01, 4'(i), 32'h3000_0000 + 32'(i * 64)});
      settle();
      chk_out($sformatf("fill%0d", i), 1, 0, 1, 0, i, 0);
      next();
    end
    mls_req(2'b01, 4'h4, 32'h3000_0100);
    settle(); chk_out("full_stall0", 0, 0, 0, 0, 4, 0); next();
    settle(); chk_out("full_stall1", 0, 0, 0, 0, 4, 0); next();
    sp_ld_done = 1;
    settle(); chk_out("full_done", 0, 0, 0, 0, 4, 0); next();
    sp_ld_done = 0;
    exp_q.push_back({2'b01, 4'h4, 32'h3000_0100});
    settle(); chk_out("full_resume", 1, 0, 1, 0, 3, 0); next();
    set_idle();
    settle(); chk("full_cnt_back", ld_outstanding, 4); next();
    sp_ld_done = 1;
    repeat (4) next();
    sp_ld_done = 0;
    settle(); chk("drain_cnt", ld_outstanding, 0); next();

    // Fence: new-weight GEMM waits for two loads to drain, MLS blocked meanwhile.
    for (int i = 0; i < 2; i++) begin
      mls_req(2'b01, 4'h9, 32'h3100_0000);
      exp_q.push_back({2'b01, 4'h9, 32'h3100_0000});
      next();
    end
    set_idle();
    gemm_valid = 1; gemm_new_weight = 1; gemm_sel = 16'h0F0F;
    settle(); chk_out("fence_enter", 0, 0, 0, 0, 2, 0); next();
    mls_req(2'b10, 4'h7, 32'h4000_0000);
    sp_ld_done = 1;
    settle(); chk_out("fence_block0", 0, 0, 0, 0, 2, 1); next();
    settle(); chk_out("fence_block1", 0, 0, 0, 0, 1, 1); next();
    sp_ld_done = 0;
    exp_q.push_back(38'h3_8_0000_0F0F);
    settle(); chk_out("fence_grant", 0, 1, 1, 0, 0, 1); next();
    gemm_valid = 0; gemm_new_weight = 0;
    exp_q.push_back(38'h2_7_4000_0000);
    settle(); chk_out("fence_exit", 1, 0, 1, 0, 0, 0); next();
    set_idle();

    // Flush aborts the fence and hands the next tie to MLS.
    mls_req(2'b01, 4'h1, 32'h5000_0000);
    exp_q.push_back(38'h1_1_5000_0000);
    next();
    set_idle();
    gemm_valid = 1; gemm_new_weight = 1; gemm_sel = 16'h00F0;
    settle(); chk_out("flush_pre", 0, 0, 0, 0, 1, 0); next();
    gemm_flush = 1;
    settle(); chk_out("flush_cycle", 0, 0, 0, 0, 1, 1); next();
    gemm_flush = 0; gemm_valid = 0; gemm_new_weight = 0;
    settle(); chk_out("flush_after", 0, 0, 0, 0, 1, 0); next();
    mls_req(2'b10, 4'h2, 32'h6000_0000);
    gemm_valid = 1; gemm_sel = 16'h0011;
    exp_q.push_back(38'h2_2_6000_0000);
    settle(); chk_out("flush_rr", 1, 0, 1, 0, 1, 0); next();
    mls_valid = 0;
    exp_q.push_back(38'h3_0_0000_0011);
    settle(); chk_out("flush_rr_gemm", 0, 1, 1, 0, 1, 0); next();
    set_idle();
    sp_ld_done = 1; next(); sp_ld_done = 0;

    // Reset while fenced with a load outstanding clears everything.
    mls_req(2'b01, 4'h6, 32'h7000_0000);
    exp_q.push_back(38'h1_6_7000_0000);
    next();
    set_idle();
    gemm_valid = 1; gemm_new_weight = 1;
    next();
    settle(); chk("rst_pre_fence", fence_busy, 1); next();
    nRST = 0;
    #2;
    chk("rst_async_fence", fence_busy, 0);
    chk("rst_async_cnt", ld_outstanding, 0);
    set_idle();
    @(negedge CLK);
    nRST = 1;
    next();
    sp_ld_done = 1;
    settle(); chk_out("rst_late_done", 0, 0, 0, 1, 0, 0); next();
    sp_ld_done = 0;
    settle(); chk_out("rst_after", 0, 0, 0, 0, 0, 0); next();

    repeat (2) next();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sp_req_arbiter.md
Name: sp_req_arbiter

Overview:
Arbitrates between the matrix load/store FU (MLS) and the GEMM FU for the single write port of the scratchpad request FIFO. Packs each granted request into the 38-bit FIFO word format and tracks outstanding scratchpad loads. Fences weight-changing GEMM ops behind all in-flight loads. Sits in execute, between the MLS/GEMM FUs and the scratchpad FIFO.

Parameters:
MAX_LD, 4, maximum outstanding scratchpad loads (1..15)
CNT_W, $clog2(MAX_LD+1), width of the outstanding-load counter

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
mls_valid  in  1  MLS request valid, held until mls_ready
mls_ready  out  1  MLS request consumed this cycle
mls_ls  in  2  01=load, 10=store; 00/11 illegal
mls_rd  in  4  destination/source matrix register
mls_addr  in  32  matrix base address
gemm_valid  in  1  GEMM request valid, held until gemm_ready
gemm_ready  out  1  GEMM request consumed this cycle
gemm_new_weight  in  1  GEMM op loads new weights (fenced)
gemm_sel  in  16  GEMM matrix select field
gemm_flush  in  1  abort fence wait, reset arbitration pointer
sp_full  in  1  scratchpad FIFO full
sp_wen  out  1  push to scratchpad FIFO
sp_wdata  out  38  FIFO word
sp_ld_done  in  1  one-cycle pulse per completed scratchpad load
ld_outstanding  out  CNT_W  current outstanding-load count
fence_busy  out  1  FSM in FENCE
arb_err  out  1  one-cycle error pulse

Behaviour:
- Reset (nRST low, async): ld_cnt=0, FSM=RUN, rr_last=GEMM (MLS wins first tie), arb_err=0. Outputs combinational from state, so sp_wen=0, mls_ready=0, gemm_ready=0 while no requests.
- Latency 0: grant, ready and sp_wen in same cycle as valid; state updates at next CLK edge.
- Word format: [37:36] op (01 load, 10 store, 11 gemm); MLS: [35:32]=mls_rd, [31:0]=mls_addr; GEMM: [35:32]={gemm_new_weight,3'b000}, [31:16]=0, [15:0]=gemm_sel. sp_wdata=0 when sp_wen=0.
- Eligibility (all require sp_full=0):
  - MLS load: FSM=RUN and ld_cnt<MAX_LD.
  - MLS store: FSM=RUN.
  - MLS illegal ls: always; consumed (mls_ready=1), no push, arb_err=1, ignores sp_full.
  - GEMM, new_weight=0: always.
  - GEMM, new_weight=1: ld_cnt==0.
- Round robin: both eligible -> grant the one not in rr_last; one eligible -> grant it. rr_last updates only on an actual push.
- Grant: requester ready=1, sp_wen=1, at most one push per cycle.
- ld_cnt: +1 on pushed load, -1 on sp_ld_done; both same cycle -> unchanged. sp_ld_done at ld_cnt=0 -> ignored, arb_err=1. Load never pushed when ld_cnt=MAX_LD.
- FSM RUN->FENCE: gemm_valid & gemm_new_weight & ld_cnt!=0 (not granted). In FENCE all MLS requests blocked so loads drain.
- FENCE->RUN: fenced GEMM granted (ld_cnt==0), or gemm_valid deasserts, or gemm_flush.
- gemm_flush (1 cycle): FSM->RUN, rr_last->GEMM; no grant to GEMM that cycle; ld_cnt kept (in-flight loads still complete).
- Reset mid-fence or with loads outstanding: all state cleared; later sp_ld_done pulses at ld_cnt=0 raise arb_err.
- fence_busy=1 iff FSM=FENCE; ld_outstanding=ld_cnt.

Test Plan:
- MLS load rd=3 addr=0x1000_0040, sp_full=0 -> same cycle sp_wen=1, sp_wdata=0x1_3_1000_0040 (op 01), mls_ready=1; ld_outstanding 0->1.
- MLS store and GEMM (sel=0x00A5, nw=0) valid together for 4 cycles after reset -> pushes alternate MLS, GEMM, MLS, GEMM; GEMM word = 0x3_0_0000_00A5.
- 4 loads with no sp_ld_done (MAX_LD=4) -> 4th pushed, 5th stalls mls_ready=0; one sp_ld_done -> 5th pushes next cycle, count stays 4.
- 2 loads outstanding, GEMM nw=1 -> fence_busy=1, new MLS store blocked; after 2 sp_ld_done, GEMM pushes word [35:32]=4'b1000, fence_busy=0.
- In FENCE assert gemm_flush -> fence_busy=0 next cycle, ld_outstanding unchanged, no GEMM push.
- mls_ls=11 with sp_full=1 -> mls_ready=1, arb_err=1, sp_wen=0; sp_ld_done at count 0 -> arb_err=1, count stays 0.
